// File: rtl/lifo_stack.sv
// Parametrised LIFO with registered top-of-stack, occupancy count, full/empty decode
// and sticky overflow/underflow flags. Optional high-water mark under `STACK_HWM_EN`.
module lifo_stack #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_data_in,
    output logic [WIDTH-1:0]     o_data_out,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_overflow,
    output logic                 o_underflow,
    output logic [ADDR_BITS:0]   o_hwm
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_C   = (ADDR_BITS + 1)'(1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS:0]   r_count;
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_do_push;
    logic                 w_do_replace;
    logic                 w_do_pop;
    logic                 w_ovf_set;
    logic                 w_unf_set;
    logic [ADDR_BITS-1:0] w_push_idx;
    logic [ADDR_BITS-1:0] w_top_idx;
    logic [ADDR_BITS-1:0] w_below_idx;
    logic [ADDR_BITS:0]   w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // push&pop on an empty stack degrades to a plain push
    assign w_do_replace = i_push && i_pop && !w_empty;
    assign w_do_push    = i_push && (!i_pop || w_empty) && !w_full;
    assign w_do_pop     = i_pop && !i_push && !w_empty;
    assign w_ovf_set    = i_push && !i_pop && w_full;
    assign w_unf_set    = i_pop && !i_push && w_empty;

    assign w_push_idx  = r_count[ADDR_BITS-1:0];
    assign w_top_idx   = ADDR_BITS'(r_count - ONE_C);
    assign w_below_idx = ADDR_BITS'(r_count - (ONE_C + ONE_C));

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push)
            w_count_nxt = r_count + ONE_C;
        else if (w_do_pop)
            w_count_nxt = r_count - ONE_C;
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_en) begin
            r_count <= w_count_nxt;
            if (w_do_push) begin
                r_mem[w_push_idx] <= i_data_in;
                r_data_out        <= i_data_in;
            end else if (w_do_replace) begin
                r_mem[w_top_idx] <= i_data_in;
                r_data_out       <= i_data_in;
            end else if (w_do_pop) begin
                r_data_out <= (r_count == ONE_C) ? '0 : r_mem[w_below_idx];
            end
            if (w_ovf_set)
                r_overflow <= 1'b1;
            if (w_unf_set)
                r_underflow <= 1'b1;
        end
    end

`ifdef STACK_HWM_EN
    logic [ADDR_BITS:0] r_hwm;

    // compares against the next count so the mark moves on the same edge as count
    always_ff @(posedge i_clk) begin
        if (!i_clr)
            r_hwm <= '0;
        else if (i_en && (w_count_nxt > r_hwm))
            r_hwm <= w_count_nxt;
    end

    assign o_hwm = r_hwm;
`else
    assign o_hwm = '0;
`endif

    assign o_data_out  = r_data_out;
    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: directed scenarios plus random traffic against a
// queue-based stack model. Build with +define+STACK_HWM_EN to match an HWM-enabled DUT.
module tb_lifo_stack;

    localparam int W     = 8;
    localparam int AB    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] data;
        logic [AB:0]  count;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
        logic [AB:0]  hwm;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr, en, push, pop;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic [AB:0]   count, hwm;
    logic          empty, full, overflow, underflow;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb_q[$];

    logic [W-1:0]  stk[$];
    bit            m_ovf, m_unf;
    int            m_hwm;

    always #5 clk = ~clk;

    lifo_stack #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .i_clk(clk), .i_clr(clr), .i_en(en), .i_push(push), .i_pop(pop),
        .i_data_in(data_in), .o_data_out(data_out), .o_count(count),
        .o_empty(empty), .o_full(full), .o_overflow(overflow),
        .o_underflow(underflow), .o_hwm(hwm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and record what the stack must look like after the edge
    task automatic step(input bit c, input bit e, input bit pu, input bit po, input logic [W-1:0] d);
        exp_t x;
        @(negedge clk);
        clr = c; en = e; push = pu; pop = po; data_in = d;
        if (!c) begin
            stk.delete();
            m_ovf = 0; m_unf = 0; m_hwm = 0;
        end else if (e) begin
            if (pu && po && stk.size() > 0)
                stk[stk.size()-1] = d;
            else if (pu) begin
                if (stk.size() == DEPTH) m_ovf = 1;
                else stk.push_back(d);
            end else if (po) begin
                if (stk.size() == 0) m_unf = 1;
                else void'(stk.pop_back());
            end
            if (stk.size() > m_hwm) m_hwm = stk.size();
        end
        x.data  = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        x.count = (AB+1)'(stk.size());
        x.empty = (stk.size() == 0);
        x.full  = (stk.size() == DEPTH);
        x.ovf   = m_ovf;
        x.unf   = m_unf;
`ifdef STACK_HWM_EN
        x.hwm   = (AB+1)'(m_hwm);
`else
        x.hwm   = '0;
`endif
        sb_q.push_back(x);
    endtask

    // Monitor: one expected entry per clock edge, checked just after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("data_out",  32'(data_out),  32'(x.data));
                chk("count",     32'(count),     32'(x.count));
                chk("empty",     32'(empty),     32'(x.empty));
                chk("full",      32'(full),      32'(x.full));
                chk("overflow",  32'(overflow),  32'(x.ovf));
                chk("underflow", 32'(underflow), 32'(x.unf));
                chk("hwm",       32'(hwm),       32'(x.hwm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b0; en = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        step(0, 0, 0, 0, 8'h00);
        // reset after random pushes, with a command in flight
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, W'($urandom));
        step(0, 1, 1, 1, 8'hA5);
        // fill, overflow, drain
        step(1, 1, 1, 0, 8'h11); step(1, 1, 1, 0, 8'h22);
        step(1, 1, 1, 0, 8'h33); step(1, 1, 1, 0, 8'h44);
        step(1, 1, 1, 0, 8'h55);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 8'h00);
        // underflow, then push keeps flag sticky
        step(1, 1, 0, 1, 8'h00);
        step(1, 1, 1, 0, 8'h0A);
        // replace top
        step(0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h01); step(1, 1, 1, 0, 8'h02);
        step(1, 1, 1, 1, 8'h7F);
        step(1, 1, 0, 1, 8'h00);
        // replace while full, push&pop while empty
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, W'(8'hC0 + i));
        step(1, 1, 1, 1, 8'h99);
        step(0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'h05);
        // enable low holds everything
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, W'($urandom));
        step(1, 0, 0, 1, 8'h00);
        // high-water mark
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, W'(8'h30 + i));
        step(1, 1, 0, 1, 8'h00); step(1, 1, 0, 1, 8'h00);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 40) != 0, ($urandom % 8) != 0, $urandom % 2 == 1,
                 $urandom % 2 == 1, W'($urandom));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
